// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receiver and transmitter.
//   - default clock / baud constants
//   - receiver FSM state encoding
//   - 3-input majority helper used by the mid-bit voter
package uart_pkg;

  localparam int unsigned UART_CLK_FREQ  = 50_000_000;
  localparam int unsigned UART_BAUD_RATE = 9600;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } uart_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_sync_edge.sv
// uart_sync_edge: 2-flop synchroniser for an asynchronous input, plus a
// delay flop used to detect a falling edge on the synchronised signal.
// Ports:
//   clk   in   system clock
//   rst   in   asynchronous active-low reset (flops reset to idle-high)
//   din   in   asynchronous input, idles high
//   sync  out  synchronised input (s2)
//   fall  out  high for one cycle when sync goes 1 -> 0
module uart_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync,
  output logic fall
);

  logic s1, s2, s3;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign sync = s2;
  assign fall = ~s2 & s3;

endmodule

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 UART receiver with mid-bit 3-sample majority voting,
// false-start rejection and framing-error detection. Bytes are not buffered;
// each good frame overwrites rx_data.
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-low reset
//   rxd        in   raw serial line (idles high, asynchronous)
//   rx_data    out  last correctly framed byte
//   rx_done    out  one-cycle strobe, rx_data valid in the same cycle
//   frame_err  out  one-cycle strobe, stop bit sampled low
//   rx_busy    out  high whenever the FSM is not idle
//
// state  | meaning
// IDLE   | line idle, waiting for a falling edge
// START  | validating the start bit (majority 1 = false start)
// DATA   | shifting in 8 data bits, LSB first
// STOP   | sampling the stop bit; decision at MID+1
// BREAK  | stop bit was low; waiting for the line to return high
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = UART_CLK_FREQ,
  parameter int unsigned BAUD_RATE = UART_BAUD_RATE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int unsigned BAUD_CNT = CLK_FREQ / BAUD_RATE;
  localparam int unsigned MID      = BAUD_CNT / 2;
  localparam int unsigned CW       = $clog2(BAUD_CNT);

  localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_CNT - 1);
  localparam logic [CW-1:0] CNT_S0   = CW'(MID - 1);
  localparam logic [CW-1:0] CNT_S1   = CW'(MID);
  localparam logic [CW-1:0] CNT_DEC  = CW'(MID + 1);

  if (BAUD_CNT < 8) begin : g_baud_chk
    $error("uart_rx_byte: CLK_FREQ/BAUD_RATE must be at least 8");
  end

  uart_state_e   state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_reg;
  logic          smp_a, smp_b;
  logic          s2, fall;
  logic          bit_end, decide, maj;

  uart_sync_edge u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (rxd),
    .sync (s2),
    .fall (fall)
  );

  assign bit_end = (baud_cnt == CNT_LAST);
  assign decide  = (baud_cnt == CNT_DEC);
  // Third sample is the live s2 at the decision cycle.
  assign maj     = maj3(smp_a, smp_b, s2);
  assign rx_busy = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      smp_a     <= 1'b0;
      smp_b     <= 1'b0;
      rx_data   <= '0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_done   <= 1'b0;
      frame_err <= 1'b0;

      if (state == ST_IDLE || state == ST_BREAK || bit_end)
        baud_cnt <= '0;
      else
        baud_cnt <= baud_cnt + 1'b1;

      if (baud_cnt == CNT_S0) smp_a <= s2;
      if (baud_cnt == CNT_S1) smp_b <= s2;

      case (state)
        ST_IDLE: begin
          if (fall) state <= ST_START;
        end
        ST_START: begin
          if (decide && maj) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
          end else if (bit_end) begin
            state   <= ST_DATA;
            bit_cnt <= '0;
          end
        end
        ST_DATA: begin
          if (decide) shift_reg <= {maj, shift_reg[7:1]};
          if (bit_end) begin
            if (bit_cnt == 3'd7) state <= ST_STOP;
            else                 bit_cnt <= bit_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          // Leave at the decision point so a back-to-back start bit is not missed.
          if (decide) begin
            baud_cnt <= '0;
            if (maj) begin
              rx_data <= shift_reg;
              rx_done <= 1'b1;
              state   <= ST_IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= ST_BREAK;
            end
          end
        end
        ST_BREAK: begin
          if (s2) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_rx_byte.md
Name: uart_rx_byte

Overview:
Asynchronous UART receiver that deserialises the 8N1 serial line into bytes. It is the stage directly upstream of the command-frame parser: it produces `rx_data` and a one-cycle `rx_done` strobe that the parser consumes. The receiver uses mid-bit majority sampling, rejects false starts and flags framing errors. Received bytes are never buffered: each new byte overwrites the previous one.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD_RATE, 9600, serial bit rate in baud.
- Derived constants (localparams, not overridable):
  - BAUD_CNT = CLK_FREQ/BAUD_RATE, with integer truncation.
  - MID = BAUD_CNT/2.
  - BAUD_CNT must be >= 8; flag this with an elaboration-time check.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  asynchronous active-low reset.
- rxd  input  1  raw serial line; idles high; asynchronous to clk.
- rx_data  output  8  last correctly framed byte; held stable between strobes.
- rx_done  output  1  one-cycle strobe; rx_data is valid in the same cycle.
- frame_err  output  1  one-cycle strobe; stop bit was sampled low.
- rx_busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset values (rst low): rx_data=8'd0, rx_done=0, frame_err=0, rx_busy=0, FSM=IDLE, all counters=0, synchroniser flops=1.
- Reset asserted mid-frame aborts the frame immediately. No strobe is emitted and rx_data is unchanged from its reset value.
- Input conditioning:
  - rxd passes through a 2-flop synchroniser (s1, s2) plus a delay flop s3.
  - Falling edge = s2==0 && s3==1.
- Bit timing:
  - baud_cnt runs 0..BAUD_CNT-1, then wraps to 0 at the end of each bit period.
  - Samples of s2 are captured at baud_cnt == MID-1, MID and MID+1.
  - Bit value = majority of the 3 samples, evaluated at baud_cnt == MID+1.
- FSM states and transitions:
  - IDLE: baud_cnt held at 0. A falling edge moves to START with baud_cnt=0.
  - START: if the majority is 1, it is a false start: go to IDLE, no strobe. Otherwise, at the end of the period go to DATA with bit_cnt=0.
  - DATA: the majority bit is shifted into shift_reg LSB-first (shift right, new bit into [7]). At the end of the period bit_cnt increments; after bit_cnt==7 completes, go to STOP.
  - STOP: the decision is taken at baud_cnt==MID+1.
    - Majority 1: rx_data<=shift_reg, rx_done=1 for the next cycle only, go to IDLE immediately. The remainder of the stop bit is not waited for, so back-to-back frames and a slightly fast transmitter are tolerated.
    - Majority 0: frame_err=1 for one cycle, rx_data unchanged, go to BREAK.
  - BREAK: wait until s2==1, then go to IDLE. A held-low line (break condition) therefore produces exactly one frame_err and no spurious frames.
- Strobe timing:
  - rx_done and frame_err are never high together.
  - Latency from the stop-bit MID+1 sample edge to a strobe is 1 clock.
  - Latency from the rxd falling edge to rx_done is about 2 + 9*BAUD_CNT + MID + 2 clocks, including synchroniser delay.
- rx_busy is combinational from the state: high in START, DATA, STOP and BREAK.
- Falling edges seen outside IDLE are ignored.
- A 1-cycle glitch on rxd during a data bit is filtered by the majority vote, provided it hits at most one of the 3 sample points.

Decomposition:
- Shared package `uart_pkg`: state encoding (IDLE, START, DATA, STOP, BREAK as a 3-bit enum) and the default CLK_FREQ / BAUD_RATE constants shared with the transmitter.
- One natural sub-module, `uart_sync_edge`: the 2-flop synchroniser plus falling-edge detector, which the transmitter-side handshake input will reuse.
- The baud counter and majority voter stay inline.

Test Plan (bench runs with CLK_FREQ=1_000_000, BAUD_RATE=62_500, so BAUD_CNT=16 and MID=8):
- Single frame 0xA5 with stop=1 -> exactly one rx_done pulse, rx_data==8'hA5 and frame_err never high; rx_busy returns low in the same cycle as the strobe.
- Back-to-back bytes FF F0 A0 7C 01 02 0D 0A with no idle gap -> eight rx_done pulses, each with the matching rx_data. No byte is lost, which covers the parser header sequence.
- rxd low for 5 clocks then high (false start) -> FSM returns to IDLE, no rx_done, no frame_err.
- Frame 0x3C with stop bit driven 0, then the line held low 40 clocks -> one frame_err pulse, no rx_done, rx_data still the previous value. The next 0x55 frame is received correctly after the line returns high.
- Frame 0x0F with a 1-clock inverted glitch at baud_cnt==MID of data bit 2 -> rx_data==8'h0F, no error.
- rst asserted during data bit 4 of 0xC3, released, then 0x81 sent -> no strobe for the aborted frame, rx_data==8'h00 until 0x81 arrives, then 8'h81.
